// File: rtl/div32_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle behind a
// start/busy/done handshake, with adder-style flags plus divide-by-zero.
module div32_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             DZ,
   output logic             OF,
   output logic             SF,
   output logic             ZF
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [5:0]       LAST    = 6'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state, state_nxt;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] dvd, dvs, rem;
   logic             neg_q, neg_r;
   logic [WIDTH:0]   shifted, trial;
   logic             accept, is_dz, is_ovf;

   function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
      return cneg(v, s & v[WIDTH-1]);
   endfunction

   assign accept  = start && ((state == IDLE) || (state == DONE));
   assign is_dz   = (B == '0);
   assign is_ovf  = sign && (A == MIN_NEG) && (B == '1);
   // Partial remainder stays below the divisor, so bit WIDTH of the trial is its sign.
   assign shifted = {rem, dvd[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_nxt = (is_dz || is_ovf) ? DONE : CALC;
            else       state_nxt = IDLE;
         end
         CALC:    if (cnt == LAST) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         Q     <= '0;
         R     <= '0;
         DZ    <= 1'b0;
         OF    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= '0;
            if (is_dz) begin
               Q  <= '1;
               R  <= A;
               DZ <= 1'b1;
               OF <= 1'b0;
            end else if (is_ovf) begin
               Q  <= MIN_NEG;
               R  <= '0;
               DZ <= 1'b0;
               OF <= 1'b1;
            end
         end else if (state == CALC) begin
            if (cnt != LAST) cnt <= cnt + 6'd1;
         end else if (state == FIX) begin
            Q  <= cneg(dvd, neg_q);
            R  <= cneg(rem, neg_r);
            DZ <= 1'b0;
            OF <= 1'b0;
         end
      end
   end

   // Iteration datapath: dvd shifts the dividend out and the quotient in.
   always_ff @(posedge clk) begin
      if (accept) begin
         dvd   <= mag(A, sign);
         dvs   <= mag(B, sign);
         rem   <= '0;
         neg_q <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
         neg_r <= sign & A[WIDTH-1];
      end else if (state == CALC) begin
         dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
         rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      end
   end

   assign busy = (state == CALC) || (state == FIX);
   assign done = (state == DONE);
   assign SF   = Q[WIDTH-1];
   assign ZF   = (Q == '0);

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: the driver queues expected results, a monitor
// checks them whenever done is presented.
module tb_div32_seq;

   logic        clk, rst_n, start, sign;
   logic [31:0] A, B, Q, R;
   logic        busy, done, DZ, OF, SF, ZF;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        of;
      int          lat;
      int          sedge;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   ndone = 0;

   div32_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .A(A), .B(B),
      .busy(busy), .done(done), .Q(Q), .R(R), .DZ(DZ), .OF(OF), .SF(SF), .ZF(ZF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops one expected result per done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         ndone++;
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1 expected no result pending");
         end else begin
            e = sb.pop_front();
            chk({e.nm, "_Q"},   Q, e.q);
            chk({e.nm, "_R"},   R, e.r);
            chk({e.nm, "_DZ"},  32'(DZ), 32'(e.dz));
            chk({e.nm, "_OF"},  32'(OF), 32'(e.of));
            chk({e.nm, "_SF"},  32'(SF), 32'(e.q[31]));
            chk({e.nm, "_ZF"},  32'(ZF), 32'(e.q == 32'd0));
            chk({e.nm, "_lat"}, 32'(cyc - e.sedge + 1), 32'(e.lat));
         end
      end
   end

   // Caller is at a negedge; start is sampled at the next posedge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] q, input logic [31:0] r,
                        input logic dz, input logic of, input int lat, input string nm);
      exp_t e;
      A = a; B = b; sign = s; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; sign = ~s;
      e.q = q; e.r = r; e.dz = dz; e.of = of; e.lat = lat; e.sedge = cyc; e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 60);
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got no done after %0d cycles, expected done", nm, n);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd;
      rst_n = 1'b0; start = 1'b0; sign = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_Q",    Q, 32'd0);
      chk("rst_R",    R, 32'd0);
      chk("rst_ZF",   32'(ZF), 32'd1);
      chk("rst_SF",   32'(SF), 32'd0);
      chk("rst_DZ",   32'(DZ), 32'd0);
      chk("rst_OF",   32'(OF), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 34, "u100_7");
      wait_done("u100_7");
      @(negedge clk);
      issue(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 34, "sm100_7");
      wait_done("sm100_7");
      // Back-to-back: start presented during the DONE cycle.
      issue(32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 34, "s100_m7");
      wait_done("s100_m7");
      @(negedge clk);
      issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 34, "sm7_m2");
      wait_done("sm7_m2");
      @(negedge clk);

      issue(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1, "dz");
      @(negedge clk);
      chk("dz_busy", 32'(busy), 32'd0);
      chk("dz_done", 32'(done), 32'd1);
      @(negedge clk);

      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1, "sovf");
      wait_done("sovf");
      @(negedge clk);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 34, "uovf");
      wait_done("uovf");
      @(negedge clk);

      // A start during CALC (would be a divide-by-zero) must be ignored.
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 34, "ignstart");
      repeat (9) @(negedge clk);
      A = 32'd5; B = 32'd0; sign = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("ignstart");
      @(negedge clk);

      // Reset in the middle of a division aborts it.
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 34, "abort");
      repeat (19) @(posedge clk);
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_Q",    Q, 32'd0);
      chk("abort_R",    R, 32'd0);
      chk("abort_ZF",   32'(ZF), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      nd = ndone;
      repeat (40) @(negedge clk);
      chk("abort_no_done", 32'(ndone - nd), 32'd0);

      issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0, 34, "u1000_10");
      wait_done("u1000_10");
      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Iterative 32-bit integer divider (radix-2 restoring) for the exp datapath.
- Inverse of the 32-bit adder: division built from repeated 33-bit trial subtraction, one quotient bit per cycle.
- Sits beside the adder/ALU behind a start/busy/done handshake; publishes quotient, remainder and condition flags in the same style as the adder (ZF, SF, OF) plus a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- sign  input  1  1 = signed (two's complement), 0 = unsigned; latched on start
- A  input  WIDTH  dividend; latched on start
- B  input  WIDTH  divisor; latched on start
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; Q/R/flags are valid from this cycle
- Q  output  WIDTH  quotient
- R  output  WIDTH  remainder
- DZ  output  1  divide by zero
- OF  output  1  signed overflow (most-negative / -1)
- SF  output  1  Q[WIDTH-1]
- ZF  output  1  Q == 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, Q=0, R=0, DZ=0, OF=0.
  - SF=0, ZF=1 (flags derived combinationally from the Q register).
  - Reset mid-operation aborts the division; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1 (edge k):
  - Latch sign, A, B.
  - Special case B==0: write Q=all-ones, R=A, DZ=1, OF=0; go to DONE. done is high in the cycle after edge k.
  - Special case sign=1, A=0x80000000, B=0xFFFFFFFF: write Q=0x80000000, R=0, OF=1, DZ=0; go to DONE.
  - Otherwise: load magnitudes (|A|, |B| if sign=1, else raw); record neg_q = sign & (A[31]^B[31]) and neg_r = sign & A[31]; clear the partial remainder; counter=0; go to CALC.
- CALC, one step per cycle, WIDTH cycles:
  - Shift {rem, dividend} left by 1.
  - Trial = rem - divisor, computed 33 bits wide.
  - If trial is non-negative: rem = trial and the quotient LSB = 1; else the quotient LSB = 0.
  - After step WIDTH (counter==WIDTH-1), go to FIX.
- FIX (one cycle):
  - Q = neg_q ? -quot : quot; R = neg_r ? -rem : rem.
  - DZ=0, OF=0; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE, unless start=1, which is handled as in IDLE. Outputs are unchanged from this point.
- Latency: normal path, done is high 34 cycles after the start edge (32 CALC + FIX + DONE). Special cases: 1 cycle.
- start is ignored while busy=1; latched operands are not disturbed.
- Q, R and flags hold their last values until the next result write. Input changes after the start edge have no effect.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- Bounds: the counter is 6 bits and stops at WIDTH-1; it never wraps.

Test Plan:
- Unsigned 100/7 (sign=0) -> done 34 cycles after start; Q=14, R=2, ZF=0, SF=0, DZ=0, OF=0.
- Signed -100/7 (A=0xFFFFFF9C, B=7, sign=1) -> Q=0xFFFFFFF2, R=0xFFFFFFFE, SF=1. Also 100/-7 -> Q=0xFFFFFFF2, R=2.
- Divide by zero (A=0x1234, B=0) -> done one cycle after start; Q=0xFFFFFFFF, R=0x1234, DZ=1, busy never high.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, sign=1) -> Q=0x80000000, R=0, OF=1, 1-cycle latency. Same operands with sign=0 -> Q=0, R=0x80000000, ZF=1, 34 cycles.
- start pulsed again at cycle 10 with new operands during 0xFFFFFFFF/1 -> ignored; result Q=0xFFFFFFFF, R=0. Back-to-back start in the DONE cycle is accepted.
- Assert rst_n=0 at cycle 20 of a division -> busy=0, done=0, Q=0, R=0, ZF=1 immediately. No done follows; the next start runs normally.
